frame_reorder_pingpong: RTL and testbench
=========================================

Name: frame_reorder_pingpong

Overview:
- Parametrised successor to the demapper stack buffer in the WiFi PHY RX path.
- Double-buffered (ping-pong) frame reorder buffer: captures one frame of samples into one bank while the other bank drains.
- Per-frame mode selects reversed (LIFO) or in-order (FIFO) readout, so back-to-back symbols stream without a stall.
- Valid/ready handshakes on both sides, programmable frame length.

Parameters:
- DATA, 12, sample width in bits.
- DEPTH, 48, entries per bank; maximum frame length.
- AD, 6, address width; must satisfy 2^AD >= DEPTH.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- frame_len  input  AD+1  samples in next frame; latched on the first accepted beat of each frame.
- mode_rev  input  1  1 = reversed readout, 0 = in-order; latched with frame_len.
- in_valid  input  1  in_data valid.
- in_ready  output  1  buffer can accept a beat.
- in_data  input  DATA  input sample.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  DATA  output sample, registered.
- out_last  output  1  marks the final sample of a frame.
- err_len  output  1  one-cycle pulse when an illegal frame_len is latched.

Behaviour:
- Storage: two banks, each DEPTH x DATA, with synchronous write and synchronous read.
- Per-bank state registers:
  - full[b]
  - len[b], AD+1 bits
  - rev[b]
- Pointers: wbank and rbank (1 bit each); wcnt and rcnt (AD+1 bits each).
- Reset (async, active-low) values:
  - wbank = rbank = 0, wcnt = rcnt = 0, full = 00.
  - out_valid = 0, out_data = 0, out_last = 0, err_len = 0.
  - in_ready = 1 after reset.
- in_ready = !full[wbank] (combinational).
- Write accept: in_valid && in_ready.
  - Write in_data to bank[wbank][wcnt].
  - If wcnt == 0, latch len[wbank] and rev[wbank] on the same edge.
  - Length rule: if frame_len == 0 or frame_len > DEPTH, latch DEPTH and pulse err_len for 1 cycle; otherwise latch frame_len.
  - If this beat is number len-1 of the frame (compare against the value latched this frame, including the first beat when len = 1): set full[wbank], toggle wbank, clear wcnt. Otherwise wcnt++.
- Read load condition: full[rbank] && (!out_valid || out_ready).
- On a read load:
  - Read address = rev[rbank] ? len-1-rcnt : rcnt.
  - out_data <= bank[rbank][address]; out_valid <= 1; out_last <= (rcnt == len-1).
  - If out_last is loaded: clear full[rbank], toggle rbank, clear rcnt. Otherwise rcnt++.
- Output clearing: if out_valid && out_ready and no load occurs this cycle, out_valid <= 0 and out_last <= 0. out_data holds its last value.
- Backpressure: while out_valid && !out_ready, out_data and out_last are held stable.
- Latency: out_valid rises on the edge after the edge that accepted the frame's final input beat.
- Throughput: 1 sample/cycle sustained in both directions when out_ready = 1. in_ready never drops in steady state.
- Bank freeing: a bank is freed on the edge its final sample loads into the output register. The writer may refill it from the next cycle.
- Set/clear conflict: a set and a clear of the same full bit never coincide, because write requires full = 0 and read requires full = 1. No priority logic is required.
- Mode and length are per frame. Changes to frame_len or mode_rev mid-frame are ignored until the next frame's first beat.
- Reset mid-operation: all buffered data and the partially written frame are discarded. No output beat is emitted after reset deassertion until a complete new frame has been written.
- Pointer range: addresses never exceed len-1, and no wrap beyond DEPTH is possible.

Test Plan:
- Reversed full frame: mode_rev=1, frame_len=48, write 0..47 continuously, out_ready=1.
  - Expect out_data 47,46,...,0, with out_last only with 0.
  - Expect out_valid high 1 cycle after the edge accepting sample 47.
- In-order short frame: mode_rev=0, frame_len=5, write 10..14.
  - Expect out 10,11,12,13,14, with out_last with 14.
- Ping-pong streaming: three back-to-back 48-sample frames (0..47, 100..147, 200..247), mode_rev=1, in_valid held high, out_ready=1.
  - Expect in_ready constantly 1.
  - Expect outputs 47..0, 147..100, 247..200 with no gap cycles.
- Backpressure: out_ready=0, stream frames with frame_len=4.
  - Expect in_ready=0 after the 8th accepted beat; the 9th beat stalls.
  - Expect out_data stable at 3 while stalled.
  - Raise out_ready: expect 3,2,1,0 then 7,6,5,4, and in_ready returns to 1 the cycle after the first bank frees.
- Illegal length: frame_len=0, then frame_len=60.
  - Expect an err_len pulse on each first beat, and each frame treated as 48 samples.
  - Also check mixed modes: frames alternating mode_rev 1/0 produce correct ordering per frame.
- Reset mid-drain: assert reset while out_valid=1 mid-frame.
  - Expect out_valid=0 and in_ready=1 immediately.
  - After release, a new 5-sample reversed frame outputs correctly, with no stale data.

Source files
------------

// File: rtl/frame_reorder_pingpong_if.sv
// Stream bundle for frame_reorder_pingpong.
//   Input side : frame_len, mode_rev, in_valid, in_data (to buffer); in_ready (from buffer)
//   Output side: out_valid, out_data, out_last, err_len (from buffer); out_ready (to buffer)
// master = producer/consumer environment, slave = the reorder buffer.
interface frame_reorder_pingpong_if #(
    parameter int unsigned DATA = 12,
    parameter int unsigned AD   = 6
);
    logic [AD:0]     frame_len;
    logic            mode_rev;
    logic            in_valid;
    logic            in_ready;
    logic [DATA-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [DATA-1:0] out_data;
    logic            out_last;
    logic            err_len;

    modport master (
        output frame_len, mode_rev, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, err_len
    );

    modport slave (
        input  frame_len, mode_rev, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, err_len
    );
endinterface

// File: rtl/frame_reorder_pingpong.sv
// Ping-pong frame reorder buffer: one bank captures a frame while the other
// drains it, either reversed (LIFO) or in order (FIFO), chosen per frame.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset
//   bus   - stream bundle (slave side): frame_len/mode_rev/in_valid/in_data in,
//           in_ready (combinational) out, out_valid/out_data/out_last/err_len
//           registered out, out_ready in.
module frame_reorder_pingpong #(
    parameter int unsigned DATA  = 12,
    parameter int unsigned DEPTH = 48,
    parameter int unsigned AD    = 6
) (
    input logic                     clk,
    input logic                     reset,
    frame_reorder_pingpong_if.slave bus
);
    localparam logic [AD:0] DEPTH_L = (AD+1)'(DEPTH);
    localparam logic [AD:0] ONE_L   = (AD+1)'(1);

    // Storage: no reset needed, a bank is only read after being fully written
    logic [DATA-1:0] mem_q [2][DEPTH];

    logic [1:0]        full_q, full_d;
    logic [1:0]        rev_q, rev_d;
    logic [1:0][AD:0]  len_q, len_d;
    logic              wbank_q, wbank_d;
    logic              rbank_q, rbank_d;
    logic [AD:0]       wcnt_q, wcnt_d;
    logic [AD:0]       rcnt_q, rcnt_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [DATA-1:0]   out_data_q, out_data_d;
    logic              err_len_q, err_len_d;

    logic              wr_en;
    logic              len_bad;
    logic [AD:0]       len_new;
    logic [AD:0]       wlen;
    logic              rd_load;
    logic [AD:0]       rlen;
    logic [AD:0]       raddr;
    logic              rd_last;
    logic [DATA-1:0]   rdata;

    // Datapath decode: length sanitising, handshakes, read address
    always_comb begin
        len_bad = (bus.frame_len == '0) || (bus.frame_len > DEPTH_L);
        len_new = len_bad ? DEPTH_L : bus.frame_len;
        wr_en   = bus.in_valid && !full_q[wbank_q];
        // First beat compares against the length being latched on this same edge
        wlen    = (wcnt_q == '0) ? len_new : len_q[wbank_q];
        rd_load = full_q[rbank_q] && (!out_valid_q || bus.out_ready);
        rlen    = len_q[rbank_q];
        raddr   = rev_q[rbank_q] ? (rlen - ONE_L - rcnt_q) : rcnt_q;
        rd_last = (rcnt_q == rlen - ONE_L);
        rdata   = mem_q[rbank_q][raddr[AD-1:0]];
    end

    // Next-state: writer fills wbank, reader drains rbank into the output register.
    // A full bit is only set when clear and only cleared when set, so the two
    // updates below never target the same bit in one cycle.
    always_comb begin
        full_d      = full_q;
        rev_d       = rev_q;
        len_d       = len_q;
        wbank_d     = wbank_q;
        rbank_d     = rbank_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        err_len_d   = 1'b0;

        if (wr_en) begin
            if (wcnt_q == '0) begin
                len_d[wbank_q] = len_new;
                rev_d[wbank_q] = bus.mode_rev;
                err_len_d      = len_bad;
            end
            if (wcnt_q == wlen - ONE_L) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = ~wbank_q;
                wcnt_d          = '0;
            end else begin
                wcnt_d = wcnt_q + ONE_L;
            end
        end

        if (rd_load) begin
            out_data_d  = rdata;
            out_valid_d = 1'b1;
            out_last_d  = rd_last;
            if (rd_last) begin
                full_d[rbank_q] = 1'b0;
                rbank_d         = ~rbank_q;
                rcnt_d          = '0;
            end else begin
                rcnt_d = rcnt_q + ONE_L;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q      <= '0;
            rev_q       <= '0;
            len_q       <= '0;
            wbank_q     <= 1'b0;
            rbank_q     <= 1'b0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            err_len_q   <= 1'b0;
        end else begin
            full_q      <= full_d;
            rev_q       <= rev_d;
            len_q       <= len_d;
            wbank_q     <= wbank_d;
            rbank_q     <= rbank_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            err_len_q   <= err_len_d;
        end
    end

    // Bank write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wbank_q][wcnt_q[AD-1:0]] <= bus.in_data;
        end
    end

    assign bus.in_ready  = !full_q[wbank_q];
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = out_data_q;
    assign bus.err_len   = err_len_q;
endmodule

// File: tb/tb_frame_reorder_pingpong.sv
// Directed bench for frame_reorder_pingpong: drives frames through the input
// handshake, records output beats with their cycle stamps, and compares them
// against hand-built expected sequences.
module tb_frame_reorder_pingpong;
    logic clk;
    logic reset;

    frame_reorder_pingpong_if #(.DATA(12), .AD(6)) bus ();

    frame_reorder_pingpong #(.DATA(12), .DEPTH(48), .AD(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Edge counter and negedge monitor
    int          cyc = 0;
    logic [11:0] oq_data[$];
    logic        oq_last[$];
    int          oq_cyc[$];
    int          acc_cyc[$];
    int          err_cyc[$];
    int          stall_cnt = 0;

    logic [11:0] exp_d[$];
    logic        exp_l[$];

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (reset && bus.out_valid && bus.out_ready) begin
            oq_data.push_back(bus.out_data);
            oq_last.push_back(bus.out_last);
            oq_cyc.push_back(cyc);
        end
        if (reset && bus.in_valid && bus.in_ready) acc_cyc.push_back(cyc);
        if (reset && bus.err_len) err_cyc.push_back(cyc);
        if (reset && bus.in_valid && !bus.in_ready) stall_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_mon();
        oq_data.delete(); oq_last.delete(); oq_cyc.delete();
        acc_cyc.delete(); err_cyc.delete(); stall_cnt = 0;
        exp_d.delete(); exp_l.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Present one beat and hold it until accepted (bounded)
    task automatic push(input logic [6:0] flen, input logic rev, input logic [11:0] d);
        bit ok;
        int n = 0;
        bus.frame_len = flen;
        bus.mode_rev  = rev;
        bus.in_data   = d;
        bus.in_valid  = 1'b1;
        forever begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk); #1;
            if (ok) break;
            n++;
            if (n > 500) break;
        end
    endtask

    task automatic send_frame(input logic [6:0] flen, input logic rev, input int base, input int n);
        for (int i = 0; i < n; i++) push(flen, rev, 12'(base + i));
    endtask

    task automatic exp_frame(input int base, input int n, input bit rev);
        for (int i = 0; i < n; i++) begin
            exp_d.push_back(rev ? 12'(base + n - 1 - i) : 12'(base + i));
            exp_l.push_back(i == n - 1);
        end
    endtask

    task automatic wait_outs(input int n, input int budget);
        int k = 0;
        while (oq_data.size() < n && k < budget) begin tick(1); k++; end
        tick(3);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.frame_len = '0;
        bus.mode_rev = 1'b0; bus.out_ready = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(1);
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 12'd0) begin n_bad++; $display("FAIL reset_out_data: got %0d want 0", bus.out_data); end
        n_cmp++; if (bus.out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
        n_cmp++; if (bus.err_len !== 1'b0) begin n_bad++; $display("FAIL reset_err_len: got %b want 0", bus.err_len); end
    endtask

    task automatic test_rev_full();
        int got, want;
        clear_mon();
        bus.out_ready = 1'b1;
        send_frame(7'd48, 1'b1, 0, 48);
        bus.in_valid = 1'b0;
        exp_frame(0, 48, 1'b1);
        wait_outs(48, 200);
        n_cmp++; if (oq_data.size() != 48) begin n_bad++; $display("FAIL rev_full_count: got %0d want 48", oq_data.size()); end
        for (int i = 0; i < exp_d.size() && i < oq_data.size(); i++) begin
            n_cmp++;
            if (oq_data[i] !== exp_d[i] || oq_last[i] !== exp_l[i]) begin
                n_bad++; $display("FAIL rev_full_beat%0d: got %0d/last %b want %0d/last %b", i, oq_data[i], oq_last[i], exp_d[i], exp_l[i]);
            end
        end
        got  = (oq_cyc.size() > 0) ? oq_cyc[0] : -1;
        want = (acc_cyc.size() > 0) ? acc_cyc[acc_cyc.size()-1] + 2 : -2;
        n_cmp++; if (got != want) begin n_bad++; $display("FAIL rev_full_latency: first out cycle %0d want %0d", got, want); end
    endtask

    task automatic test_inorder_short();
        clear_mon();
        bus.out_ready = 1'b1;
        push(7'd5, 1'b0, 12'd10);
        // Length/mode changes after the first beat must be ignored
        for (int i = 1; i < 5; i++) push(7'd2, 1'b1, 12'(10 + i));
        bus.in_valid = 1'b0;
        exp_frame(10, 5, 1'b0);
        wait_outs(5, 50);
        n_cmp++; if (oq_data.size() != 5) begin n_bad++; $display("FAIL short_count: got %0d want 5", oq_data.size()); end
        for (int i = 0; i < exp_d.size() && i < oq_data.size(); i++) begin
            n_cmp++;
            if (oq_data[i] !== exp_d[i] || oq_last[i] !== exp_l[i]) begin
                n_bad++; $display("FAIL short_beat%0d: got %0d/last %b want %0d/last %b", i, oq_data[i], oq_last[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int span;
        clear_mon();
        bus.out_ready = 1'b1;
        send_frame(7'd48, 1'b1, 0, 48);
        send_frame(7'd48, 1'b1, 100, 48);
        send_frame(7'd48, 1'b1, 200, 48);
        bus.in_valid = 1'b0;
        exp_frame(0, 48, 1'b1); exp_frame(100, 48, 1'b1); exp_frame(200, 48, 1'b1);
        wait_outs(144, 400);
        n_cmp++; if (stall_cnt != 0) begin n_bad++; $display("FAIL b2b_in_ready: %0d stall cycles want 0", stall_cnt); end
        n_cmp++; if (oq_data.size() != 144) begin n_bad++; $display("FAIL b2b_count: got %0d want 144", oq_data.size()); end
        span = (oq_cyc.size() > 0) ? oq_cyc[oq_cyc.size()-1] - oq_cyc[0] : -1;
        n_cmp++; if (span != 143) begin n_bad++; $display("FAIL b2b_no_gap: output span %0d cycles want 143", span); end
        for (int i = 0; i < exp_d.size() && i < oq_data.size(); i++) begin
            n_cmp++;
            if (oq_data[i] !== exp_d[i] || oq_last[i] !== exp_l[i]) begin
                n_bad++; $display("FAIL b2b_beat%0d: got %0d/last %b want %0d/last %b", i, oq_data[i], oq_last[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int e = 0;
        int got;
        clear_mon();
        bus.out_ready = 1'b0;
        exp_frame(0, 4, 1'b1); exp_frame(4, 4, 1'b1); exp_frame(8, 4, 1'b1);
        fork
            begin
                send_frame(7'd4, 1'b1, 0, 12);
                bus.in_valid = 1'b0;
            end
            begin
                tick(14);
                n_cmp++; if (acc_cyc.size() != 8) begin n_bad++; $display("FAIL bp_accepted: got %0d want 8", acc_cyc.size()); end
                n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready_low: got %b want 0", bus.in_ready); end
                n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid: got %b want 1", bus.out_valid); end
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    n_cmp++;
                    if (bus.out_data !== 12'd3 || bus.out_last !== 1'b0) begin
                        n_bad++; $display("FAIL bp_hold%0d: got %0d/last %b want 3/last 0", k, bus.out_data, bus.out_last);
                    end
                end
                tick(1);
                e = cyc;
                bus.out_ready = 1'b1;
                wait_outs(12, 60);
            end
        join
        n_cmp++; if (oq_data.size() != 12) begin n_bad++; $display("FAIL bp_count: got %0d want 12", oq_data.size()); end
        got = (acc_cyc.size() > 8) ? acc_cyc[8] : -1;
        n_cmp++; if (got != e + 3) begin n_bad++; $display("FAIL bp_in_ready_return: 9th beat at %0d want %0d", got, e + 3); end
        got = (oq_cyc.size() == 12) ? oq_cyc[11] - oq_cyc[0] : -1;
        n_cmp++; if (got != 11 || oq_cyc.size() == 0 || oq_cyc[0] != e) begin n_bad++; $display("FAIL bp_drain_timing: span %0d want 11 starting at %0d", got, e); end
        for (int i = 0; i < exp_d.size() && i < oq_data.size(); i++) begin
            n_cmp++;
            if (oq_data[i] !== exp_d[i] || oq_last[i] !== exp_l[i]) begin
                n_bad++; $display("FAIL bp_beat%0d: got %0d/last %b want %0d/last %b", i, oq_data[i], oq_last[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_illegal_len();
        int got, want;
        clear_mon();
        bus.out_ready = 1'b1;
        send_frame(7'd0, 1'b1, 0, 48);
        send_frame(7'd60, 1'b0, 100, 48);
        send_frame(7'd3, 1'b1, 200, 3);
        bus.in_valid = 1'b0;
        exp_frame(0, 48, 1'b1); exp_frame(100, 48, 1'b0); exp_frame(200, 3, 1'b1);
        wait_outs(99, 300);
        n_cmp++; if (err_cyc.size() != 2) begin n_bad++; $display("FAIL err_count: got %0d pulses want 2", err_cyc.size()); end
        got  = (err_cyc.size() > 0) ? err_cyc[0] : -1;
        want = (acc_cyc.size() > 0) ? acc_cyc[0] + 1 : -2;
        n_cmp++; if (got != want) begin n_bad++; $display("FAIL err_pulse0_cycle: got %0d want %0d", got, want); end
        got  = (err_cyc.size() > 1) ? err_cyc[1] : -1;
        want = (acc_cyc.size() > 48) ? acc_cyc[48] + 1 : -2;
        n_cmp++; if (got != want) begin n_bad++; $display("FAIL err_pulse1_cycle: got %0d want %0d", got, want); end
        n_cmp++; if (oq_data.size() != 99) begin n_bad++; $display("FAIL err_out_count: got %0d want 99", oq_data.size()); end
        for (int i = 0; i < exp_d.size() && i < oq_data.size(); i++) begin
            n_cmp++;
            if (oq_data[i] !== exp_d[i] || oq_last[i] !== exp_l[i]) begin
                n_bad++; $display("FAIL err_beat%0d: got %0d/last %b want %0d/last %b", i, oq_data[i], oq_last[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        bus.out_ready = 1'b0;
        send_frame(7'd5, 1'b1, 0, 5);
        push(7'd5, 1'b1, 12'd20);
        push(7'd5, 1'b1, 12'd21);
        bus.in_valid = 1'b0;
        tick(2);
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_pre_valid: got %b want 1", bus.out_valid); end
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_in_ready: got %b want 1", bus.in_ready); end
        tick(2);
        reset = 1'b1;
        bus.out_ready = 1'b1;
        tick(10);
        n_cmp++; if (oq_data.size() != 0) begin n_bad++; $display("FAIL rmid_stale: got %0d beats want 0", oq_data.size()); end
        clear_mon();
        send_frame(7'd5, 1'b1, 50, 5);
        bus.in_valid = 1'b0;
        exp_frame(50, 5, 1'b1);
        wait_outs(5, 50);
        tick(5);
        n_cmp++; if (oq_data.size() != 5) begin n_bad++; $display("FAIL rmid_count: got %0d want 5", oq_data.size()); end
        for (int i = 0; i < exp_d.size() && i < oq_data.size(); i++) begin
            n_cmp++;
            if (oq_data[i] !== exp_d[i] || oq_last[i] !== exp_l[i]) begin
                n_bad++; $display("FAIL rmid_beat%0d: got %0d/last %b want %0d/last %b", i, oq_data[i], oq_last[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rev_full();
        test_inorder_short();
        test_back_to_back();
        test_backpressure();
        test_illegal_len();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
